// File: rtl/bus_grant_arbiter.sv
// Round-robin arbiter over 32 bus sources with a registered one-hot grant,
// a one-cycle turnaround between owners and an optional hold-time limit.
module bus_grant_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic        i_clock,
   input  logic        i_clear,
   input  logic [31:0] i_req,
   input  logic        i_release,
   output logic [31:0] o_grant,
   output logic        o_grant_valid,
   output logic [4:0]  o_owner,
   output logic        o_timeout,
   output logic [1:0]  o_state
);

   localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_GRANT = 2'b01,
      S_TURN  = 2'b10
   } state_t;

   state_t        r_state;
   logic [4:0]    r_last;
   logic [CW-1:0] r_hold;
   logic [31:0]   r_grant;
   logic          r_grant_valid;
   logic [4:0]    r_owner;
   logic          r_timeout;

   logic          w_found;
   logic [4:0]    w_win;
   logic [4:0]    w_idx;
   logic          w_limit;
   logic          w_voluntary;

   // Search upward from the source after the last winner, wrapping modulo 32.
   always_comb begin
      w_found = 1'b0;
      w_win   = 5'd0;
      w_idx   = 5'd0;
      for (int i = 0; i < 32; i++) begin
         w_idx = r_last + 5'd1 + 5'(i);
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_limit     = (MAX_HOLD != 0) && (r_hold == HOLD_LIMIT);
   assign w_voluntary = i_release || !i_req[r_owner];

   always_ff @(posedge i_clock) begin
      if (!i_clear) begin
         r_state       <= S_IDLE;
         r_last        <= 5'd31;
         r_hold        <= '0;
         r_grant       <= '0;
         r_grant_valid <= 1'b0;
         r_owner       <= 5'd0;
         r_timeout     <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_GRANT: begin
               if (w_voluntary || w_limit) begin
                  r_state       <= S_TURN;
                  r_grant       <= '0;
                  r_grant_valid <= 1'b0;
                  r_owner       <= 5'd0;
                  // Pulse only when the hold limit alone ended the tenure.
                  r_timeout     <= w_limit && !w_voluntary;
               end else if (r_hold != '1) begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            S_IDLE, S_TURN: begin
               if (w_found) begin
                  r_state       <= S_GRANT;
                  r_grant       <= 32'd1 << w_win;
                  r_grant_valid <= 1'b1;
                  r_owner       <= w_win;
                  r_last        <= w_win;
                  r_hold        <= CW'(1);
               end else begin
                  r_state       <= S_IDLE;
                  r_grant       <= '0;
                  r_grant_valid <= 1'b0;
                  r_owner       <= 5'd0;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_grant       <= '0;
               r_grant_valid <= 1'b0;
               r_owner       <= 5'd0;
            end
         endcase
      end
   end

   assign o_grant       = r_grant;
   assign o_grant_valid = r_grant_valid;
   assign o_owner       = r_owner;
   assign o_timeout     = r_timeout;
   assign o_state       = r_state;

endmodule
